alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/rr_arbiter_2.sv | 13 +
 rtl/alu_req_arbiter.sv | 119 +++++++++++
 tb/tb_alu_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: FSM states, ALU function
// codes and default operand/result widths.
package alu_ctrl_pkg;

    localparam int ALU_DATA_W = 4;
    localparam int ALU_FUNC_W = 3;
    localparam int ALU_RES_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    localparam logic [2:0] FN_ADD_ALT = 3'b000;
    localparam logic [2:0] FN_ADD     = 3'b001;
    localparam logic [2:0] FN_NORNAND = 3'b010;
    localparam logic [2:0] FN_ANYONE  = 3'b011;
    localparam logic [2:0] FN_PATTERN = 3'b100;
    localparam logic [2:0] FN_CONCAT  = 3'b101;
    localparam logic [2:0] FN_XORXNOR = 3'b110;
    localparam logic [2:0] FN_HOLD    = 3'b111;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester named by prio (0 = requester 0, 1 = requester 1).
module rr_arbiter_2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       prio,
    output logic [1:0] grant
);

    assign grant[0] = req0 && (!req1 || !prio);
    assign grant[1] = req1 && (!req0 || prio);

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two requesters: round-robin accept,
// one command in flight, response held until the owner consumes it.
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int FUNC_W = ALU_FUNC_W,
    parameter int RES_W  = ALU_RES_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req0_valid,
    input  logic [FUNC_W-1:0] req0_func,
    input  logic [DATA_W-1:0] req0_a,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [FUNC_W-1:0] req1_func,
    input  logic [DATA_W-1:0] req1_a,
    output logic              req1_ready,
    output logic [FUNC_W-1:0] alu_func,
    output logic [DATA_W-1:0] alu_a,
    input  logic [RES_W-1:0]  alu_result,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        op_count
);

    localparam logic [FUNC_W-1:0] FUNC_HOLD    = FUNC_W'(FN_HOLD);
    localparam logic [FUNC_W-1:0] FUNC_ILLEGAL = FUNC_W'(FN_ADD_ALT);

    state_t            state_q;
    logic              prio_q;
    logic              gnt_q;
    logic [FUNC_W-1:0] func_q;
    logic [DATA_W-1:0] a_q;
    logic              can_accept;
    logic [1:0]        grant;
    logic [FUNC_W-1:0] sel_func;
    logic [DATA_W-1:0] sel_a;
    logic              rsp_taken;
    logic              in_issue;

    // Accepting is gated by Reset so no command slips in during a reset cycle.
    assign can_accept = (state_q == ST_IDLE) && !Reset;

    rr_arbiter_2 u_rr (
        .req0  (req0_valid && can_accept),
        .req1  (req1_valid && can_accept),
        .prio  (prio_q),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel_func   = grant[1] ? req1_func : req0_func;
    assign sel_a      = grant[1] ? req1_a    : req0_a;
    assign rsp_taken  = (state_q == ST_RESPOND) && (gnt_q ? rsp1_ready : rsp0_ready);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            op_count <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        gnt_q <= grant[1];
                        if (sel_func == FUNC_ILLEGAL) begin
                            state_q  <= ST_RESPOND;
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state_q <= ST_CAPTURE;
                ST_CAPTURE: begin
                    rsp_data <= alu_result;
                    rsp_err  <= 1'b0;
                    state_q  <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (rsp_taken) begin
                        state_q  <= ST_IDLE;
                        op_count <= op_count + 8'd1;
                        prio_q   <= !gnt_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Command payload only matters while ISSUE drives it, so it carries no reset.
    always_ff @(posedge Clock) begin
        if (|grant) begin
            func_q <= sel_func;
            a_q    <= sel_a;
        end
    end

    assign in_issue   = (state_q == ST_ISSUE) && !Reset;
    assign alu_func   = in_issue ? func_q : FUNC_HOLD;
    assign alu_a      = in_issue ? a_q : '0;
    assign rsp0_valid = (state_q == ST_RESPOND) && !gnt_q && !Reset;
    assign rsp1_valid = (state_q == ST_RESPOND) && gnt_q && !Reset;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: stub registered ALU with B=0, command queues per
// requester, and a scoreboard of expected responses filled on accept.
module tb_alu_req_arbiter;
    import alu_ctrl_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0] req0_func = '0, req1_func = '0;
    logic [3:0] req0_a = '0, req1_a = '0;
    logic       req0_ready, req1_ready;
    logic [2:0] alu_func;
    logic [3:0] alu_a;
    logic [7:0] alu_result = '0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err, busy;
    logic [7:0] op_count;

    always #5 Clock = ~Clock;

    alu_req_arbiter #(.DATA_W(4), .FUNC_W(3), .RES_W(8)) dut (
        .Clock(Clock), .Reset(Reset),
        .req0_valid(req0_valid), .req0_func(req0_func), .req0_a(req0_a), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_func(req1_func), .req1_a(req1_a), .req1_ready(req1_ready),
        .alu_func(alu_func), .alu_a(alu_a), .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    // Stub ALU with operand B tied to zero; hold keeps the last result.
    function automatic logic [7:0] alu_fn(input logic [2:0] f, input logic [3:0] a, input logic [7:0] prev);
        case (f)
            FN_ADD:     return {4'h0, a};
            FN_NORNAND: return {4'hF, ~a};
            FN_ANYONE:  return {7'd0, |a};
            FN_PATTERN: return {a, a};
            FN_CONCAT:  return {a, 4'h0};
            FN_XORXNOR: return {~a, a};
            default:    return prev;
        endcase
    endfunction

    always @(posedge Clock) alu_result <= alu_fn(alu_func, alu_a, alu_result);

    typedef struct { logic [2:0] func; logic [3:0] a; logic [7:0] data; logic err; } cmd_t;
    typedef struct { int r; logic [7:0] data; logic err; int acc; } sb_t;
    typedef struct { int r; logic [2:0] func; logic [3:0] a; logic [7:0] data; logic err; } vec_t;

    cmd_t cq0[$], cq1[$];
    sb_t  sb[$];
    int   grants[$];
    bit   en0 = 0, en1 = 0, rr0 = 0, rr1 = 0, rst_v = 1;
    int   cyc = 0, done_cnt = 0, n_pass = 0, n_tot = 0, model_cnt = 0;
    bit   issue_exp = 0, pv0 = 0, pv1 = 0;
    logic [2:0] issue_func;
    logic [3:0] issue_a;
    logic [7:0] last_data;
    logic       last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive();
        Reset      = rst_v;
        rsp0_ready = rr0;
        rsp1_ready = rr1;
        req0_valid = en0 && (cq0.size() > 0);
        req1_valid = en1 && (cq1.size() > 0);
        if (cq0.size() > 0) begin req0_func = cq0[0].func; req0_a = cq0[0].a; end
        if (cq1.size() > 0) begin req1_func = cq1[0].func; req1_a = cq1[0].a; end
    endtask

    task automatic step();
        @(posedge Clock); #1; drive();
        @(negedge Clock); #1;
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin step(); n++; end
        chk(name, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic accept(input int r);
        cmd_t c;
        int   qs = (r == 1) ? cq1.size() : cq0.size();
        chk("ready_needs_valid", 32'((r == 1) ? req1_valid : req0_valid), 32'd1);
        chk("accept_has_cmd", 32'(qs > 0), 32'd1);
        if (qs == 0) return;
        if (r == 1) c = cq1.pop_front(); else c = cq0.pop_front();
        sb.push_back('{r, c.data, c.err, cyc});
        grants.push_back(r);
        if (!c.err) begin issue_exp = 1; issue_func = c.func; issue_a = c.a; end
    endtask

    task automatic respond(input int r, input logic v, input logic rdy);
        logic pv = (r == 1) ? pv1 : pv0;
        if (v) begin
            if (sb.size() == 0) chk("rsp_spurious", 32'(v), 32'd0);
            else begin
                if (!pv) begin
                    chk("rsp_owner", r, sb[0].r);
                    chk("rsp_latency", cyc - sb[0].acc, sb[0].err ? 1 : 3);
                end
                chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                if (rdy) begin
                    last_data = rsp_data;
                    last_err  = rsp_err;
                    void'(sb.pop_front());
                    done_cnt++;
                    model_cnt = (model_cnt + 1) % 256;
                end
            end
        end
        if (r == 1) pv1 = v; else pv0 = v;
    endtask

    always @(negedge Clock) begin
        cyc++;
        if (Reset) begin
            pv0 = 0; pv1 = 0; issue_exp = 0;
        end else begin
            if (issue_exp) begin
                chk("alu_func_issue", 32'(alu_func), 32'(issue_func));
                chk("alu_a_issue", 32'(alu_a), 32'(issue_a));
                issue_exp = 0;
            end else begin
                chk("alu_hold", 32'({alu_func, alu_a}), 32'({FN_HOLD, 4'h0}));
            end
            chk("one_ready", 32'(req0_ready && req1_ready), 32'd0);
            chk("one_rsp", 32'(rsp0_valid && rsp1_valid), 32'd0);
            if (req0_ready || req1_ready) chk("ready_only_idle", 32'(busy), 32'd0);
            chk("op_count", 32'(op_count), 32'(model_cnt));
            if (req0_ready) accept(0);
            if (req1_ready) accept(1);
            respond(0, rsp0_valid, rsp0_ready);
            respond(1, rsp1_valid, rsp1_ready);
        end
    end

    task automatic do_reset();
        rst_v = 1; step(); step();
        cq0.delete(); cq1.delete(); sb.delete(); grants.delete();
        model_cnt = 0; en0 = 0; en1 = 0;
        rst_v = 0; step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, done %0d", done_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        int   n, base;
        vt[0] = '{0, FN_ADD,     4'h3, 8'h03, 1'b0};
        vt[1] = '{1, FN_NORNAND, 4'h5, 8'hFA, 1'b0};
        vt[2] = '{0, FN_ANYONE,  4'h0, 8'h00, 1'b0};
        vt[3] = '{1, FN_ANYONE,  4'h8, 8'h01, 1'b0};
        vt[4] = '{0, FN_PATTERN, 4'hC, 8'hCC, 1'b0};
        vt[5] = '{1, FN_CONCAT,  4'h7, 8'h70, 1'b0};
        vt[6] = '{0, FN_XORXNOR, 4'h6, 8'h96, 1'b0};
        vt[7] = '{1, FN_ADD_ALT, 4'hF, 8'h00, 1'b1};
        vt[8] = '{1, FN_ADD,     4'hF, 8'h0F, 1'b0};

        // Reset values while a request is already pending
        cq0.push_back('{FN_ADD, 4'h3, 8'h03, 1'b0});
        en0 = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_req0_ready", 32'(req0_ready), 32'd0);
            chk("rst_req1_ready", 32'(req1_ready), 32'd0);
            chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
            chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
            chk("rst_alu", 32'({alu_func, alu_a}), 32'({FN_HOLD, 4'h0}));
            chk("rst_rsp_data", 32'(rsp_data), 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
            chk("rst_op_count", 32'(op_count), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end

        // Single add: accepted on the first cycle out of reset
        rst_v = 0; rr0 = 1; rr1 = 1; en1 = 1;
        step();
        chk("first_accept", 32'(req0_ready), 32'd1);
        run_until(1, 20, "single_add_done");
        step();
        chk("single_add_count", 32'(op_count), 32'd1);
        chk("single_add_data", 32'(last_data), 32'h03);

        // Function table, alternating requesters
        for (int i = 0; i < 9; i++) begin
            if (vt[i].r == 1) cq1.push_back('{vt[i].func, vt[i].a, vt[i].data, vt[i].err});
            else              cq0.push_back('{vt[i].func, vt[i].a, vt[i].data, vt[i].err});
            run_until(done_cnt + 1, 20, "tbl_done");
            chk("tbl_data", 32'(last_data), 32'(vt[i].data));
            chk("tbl_err", 32'(last_err), 32'(vt[i].err));
        end

        // Contention: both requesters continuously valid
        do_reset();
        en0 = 1; en1 = 1; rr0 = 1; rr1 = 1;
        base = done_cnt;
        for (int i = 0; i < 4; i++) begin
            cq0.push_back('{FN_ADD, 4'(i), 8'(i), 1'b0});
            cq1.push_back('{FN_CONCAT, 4'(i + 1), {4'(i + 1), 4'h0}, 1'b0});
        end
        run_until(base + 8, 100, "rr_done");
        step();
        chk("rr_op_count", 32'(op_count), 32'd8);
        chk("rr_grants", grants.size(), 8);
        for (int k = 0; k < grants.size() && k < 8; k++) chk("rr_order", grants[k], k % 2);

        // Backpressure on requester 0 with requester 1 waiting, then dropping
        base = done_cnt;
        rr0 = 0; rr1 = 1; en0 = 1; en1 = 1;
        cq0.push_back('{FN_PATTERN, 4'h9, 8'h99, 1'b0});
        cq1.push_back('{FN_ADD, 4'h5, 8'h05, 1'b0});
        n = 0;
        while (!rsp0_valid && n < 20) begin step(); n++; end
        chk("bp_rsp_seen", 32'(rsp0_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) en1 = 0;
            step();
            chk("bp_valid", 32'(rsp0_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'h99);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
        end
        rr0 = 1;
        step();
        step();
        chk("bp_idle_reentered", 32'(busy), 32'd0);
        chk("drop_no_effect", 32'(req1_ready), 32'd0);
        step();
        chk("drop_still_idle", 32'(busy), 32'd0);
        en1 = 1;
        run_until(base + 2, 30, "bp_done");

        // Reset pulsed during CAPTURE aborts the command
        base = done_cnt;
        cq0.push_back('{FN_ADD, 4'h7, 8'h07, 1'b0});
        en0 = 1; rr0 = 1;
        n = 0;
        while (sb.size() == 0 && n < 20) begin step(); n++; end
        chk("rm_accept", sb.size(), 1);
        step();
        chk("rm_issue_busy", 32'(busy), 32'd1);
        rst_v = 1;
        step();
        rst_v = 0; sb.delete(); model_cnt = 0;
        step();
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rm_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rm_op_count", 32'(op_count), 32'd0);
        chk("rm_alu_func", 32'(alu_func), 32'(FN_HOLD));
        repeat (5) step();
        chk("rm_no_rsp", done_cnt, base);

        // 256 completions wrap op_count to zero
        do_reset();
        en0 = 1; en1 = 1; rr0 = 1; rr1 = 1;
        base = done_cnt;
        for (int i = 0; i < 128; i++) begin
            cq0.push_back('{FN_ADD, 4'(i), {4'h0, 4'(i)}, 1'b0});
            cq1.push_back('{FN_PATTERN, 4'(i + 3), {4'(i + 3), 4'(i + 3)}, 1'b0});
        end
        run_until(base + 256, 2500, "wrap_done");
        step();
        chk("wrap_op_count", 32'(op_count), 32'd0);
        chk("wrap_completions", done_cnt - base, 256);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
